// File: rtl/s16_bit_serial_subtractor.sv
// s16_bit_serial_subtractor
//   Multi-cycle two's-complement subtractor: diff = a - b - borrow_in (mod 2^WIDTH),
//   computed CHUNK bits per cycle as a + ~b + carry, least-significant chunk first.
//   Operands arrive over an in_valid/in_ready handshake. The result leaves over an
//   out_valid/out_ready handshake.
//
//   Optional feature macro: SUB_FLAGS_EN. When it is defined, the overflow and zero
//   ports and their logic are present.
//
// Ports
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      a/b/borrow_in valid
//   in_ready   out  1      block can accept operands (IDLE only)
//   a          in   WIDTH  minuend
//   b          in   WIDTH  subtrahend
//   borrow_in  in   1      borrow into bit 0
//   out_valid  out  1      diff/borrow_out/flags valid (DONE only)
//   out_ready  in   1      consumer accepts the result
//   diff       out  WIDTH  a - b - borrow_in; only meaningful while out_valid=1
//   borrow_out out  1      1 when unsigned a < b + borrow_in
//   overflow   out  1      signed overflow (SUB_FLAGS_EN only)
//   zero       out  1      diff == 0 (SUB_FLAGS_EN only)
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for operands, in_ready=1
// RUN   | one chunk per cycle, the counter selects the chunk
// DONE  | result held stable with out_valid=1 until out_ready

module s16_bit_serial_subtractor #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
`ifdef SUB_FLAGS_EN
  ,
  output logic             overflow,
  output logic             zero
`endif
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  if ((CHUNK < 1) || ((WIDTH % CHUNK) != 0)) begin : g_chunk_check
    $error("s16_bit_serial_subtractor: CHUNK must divide WIDTH");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic [CHUNK:0]   sum;
  logic [WIDTH-1:0] diff_next;
  logic             last_chunk;

  // One ripple slice of a + ~b + carry; the top bit of sum is the carry into the next chunk.
  always_comb begin
    a_chunk   = a_r[cnt*CHUNK +: CHUNK];
    b_chunk   = b_r[cnt*CHUNK +: CHUNK];
    sum       = {1'b0, a_chunk} + {1'b0, ~b_chunk} + {{CHUNK{1'b0}}, carry};
    diff_next = diff;
    diff_next[cnt*CHUNK +: CHUNK] = sum[CHUNK-1:0];
    last_chunk = (cnt == CW'(NCHUNK - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      a_r        <= '0;
      b_r        <= '0;
      carry      <= 1'b0;
      cnt        <= '0;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
`ifdef SUB_FLAGS_EN
      overflow   <= 1'b0;
      zero       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          // in_ready is 1 throughout IDLE, so in_valid alone completes the handshake.
          if (in_valid) begin
            a_r      <= a;
            b_r      <= b;
            carry    <= ~borrow_in;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          diff  <= diff_next;
          carry <= sum[CHUNK];
          cnt   <= cnt + CW'(1);
          if (last_chunk) begin
            borrow_out <= ~sum[CHUNK];
            out_valid  <= 1'b1;
`ifdef SUB_FLAGS_EN
            overflow   <= (a_r[WIDTH-1] != b_r[WIDTH-1]) && (diff_next[WIDTH-1] != a_r[WIDTH-1]);
            zero       <= ~|diff_next;
`endif
            state      <= DONE;
          end
        end
        DONE: begin
          // in_ready comes back only on the following cycle: no same-cycle pass-through.
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_s16_bit_serial_subtractor.sv
module tb_s16_bit_serial_subtractor;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        borrow_in;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] diff;
  logic        borrow_out;
`ifdef SUB_FLAGS_EN
  logic        overflow;
  logic        zero;
`endif

  int checks = 0;
  int errors = 0;

  s16_bit_serial_subtractor #(.WIDTH(16), .CHUNK(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .borrow_in  (borrow_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .diff       (diff),
    .borrow_out (borrow_out)
`ifdef SUB_FLAGS_EN
    ,
    .overflow   (overflow),
    .zero       (zero)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on the operands.
  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_, input logic tbin,
                        input int hold, input string tag);
    int          lat;
    int          sd;
    logic [15:0] exp_diff;
    logic        exp_bout;
    logic        exp_ovf;
    exp_diff = 16'(int'(ta) - int'(tb_) - int'(tbin));
    exp_bout = (int'(ta) < (int'(tb_) + int'(tbin)));
    sd       = int'($signed(ta)) - int'($signed(tb_)) - int'(tbin);
    exp_ovf  = (sd > 32767) || (sd < -32768);

    @(negedge clk);
    a = ta; b = tb_; borrow_in = tbin; in_valid = 1'b1; out_ready = 1'b0;
    chk({tag, " in_ready_idle"}, in_ready, 1);
    @(posedge clk); #1;
    // Operand and in_valid changes after acceptance must be ignored.
    lat = 0;
    while (!out_valid && lat < 20) begin
      in_valid  = 1'($urandom);
      a         = 16'($urandom);
      b         = 16'($urandom);
      borrow_in = 1'($urandom);
      out_ready = 1'($urandom);
      @(posedge clk); #1;
      lat++;
      if (!out_valid) chk({tag, " in_ready_run"}, in_ready, 0);
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk({tag, " latency"}, lat, 4);
    chk({tag, " diff"}, diff, exp_diff);
    chk({tag, " borrow_out"}, borrow_out, exp_bout);
`ifdef SUB_FLAGS_EN
    chk({tag, " overflow"}, overflow, exp_ovf);
    chk({tag, " zero"}, zero, (exp_diff == 16'h0));
`else
    if (exp_ovf) lat = lat;
`endif
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      a = 16'($urandom); b = 16'($urandom); borrow_in = 1'($urandom);
      in_valid = 1'($urandom);
      @(posedge clk); #1;
      chk({tag, " hold_valid"}, out_valid, 1);
      chk({tag, " hold_diff"}, diff, exp_diff);
      chk({tag, " hold_bout"}, borrow_out, exp_bout);
      chk({tag, " hold_in_ready"}, in_ready, 0);
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    chk({tag, " valid_before_hs"}, out_valid, 1);
    chk({tag, " in_ready_done"}, in_ready, 0);
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, " valid_after_hs"}, out_valid, 0);
    chk({tag, " in_ready_after_hs"}, in_ready, 1);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; borrow_in = 1'b0; out_ready = 1'b0;
    #12;
    chk("reset in_ready", in_ready, 1);
    chk("reset out_valid", out_valid, 0);
    chk("reset diff", diff, 0);
    chk("reset borrow_out", borrow_out, 0);
`ifdef SUB_FLAGS_EN
    chk("reset overflow", overflow, 0);
    chk("reset zero", zero, 0);
`endif
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    run_op(16'h1234, 16'h0034, 1'b0, 10, "v1");
    run_op(16'h0000, 16'h0001, 1'b0, 1, "v2");
    run_op(16'h8000, 16'h0001, 1'b0, 0, "v3");
    run_op(16'h0005, 16'h0004, 1'b1, 2, "v4");
    run_op(16'hFFFF, 16'h7FFF, 1'b1, 0, "v5");
    run_op(16'h0000, 16'h0000, 1'b1, 0, "v6");

    // Reset in the middle of RUN: everything returns to reset values at once.
    @(negedge clk);
    a = 16'hABCD; b = 16'h1234; borrow_in = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("midrun out_valid", out_valid, 0);
    chk("midrun in_ready", in_ready, 1);
    chk("midrun diff", diff, 0);
    chk("midrun borrow_out", borrow_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(16'h0010, 16'h0001, 1'b0, 0, "post_reset");

    for (int n = 0; n < 25; n++) begin
      logic [15:0] ra;
      logic [15:0] rb;
      ra = 16'($urandom);
      rb = (n % 5 == 0) ? ra : 16'($urandom);
      run_op(ra, rb, 1'($urandom), int'($urandom_range(0, 3)), $sformatf("rand%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
